multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 The block SHALL have these ports, clock and reset first; it SHALL use one clock, and reset SHALL be synchronous and active-high:
  CLK_in  in  1  system clock, all state changes on posedge
  Reset_in  in  1  synchronous active-high reset
  Opcode_in  in  6  opcode field of instruction register, valid from ID onward
  Zero_in  in  1  ALU zero flag, sampled in EXE
  State_out  out  3  current FSM state code
  IRWrite_en  out  1  load instruction register
  PCWrite_en  out  1  PC takes Address_in at this posedge
  PCHalt_en  out  1  always ~PCWrite_en, drives PC Halt_en
  PCSrc_out  out  2  00 PC+4, 01 branch target, 10 jump target
  ALUSrcB_out  out  1  0 register B, 1 sign-extended immediate
  MemRead_en  out  1  data memory read
  MemWrite_en  out  1  data memory write
  RegWrite_en  out  1  register file write
  MemToReg_out  out  1  1 write-back from memory data
  RegDst_out  out  1  1 rd, 0 rt
  InstrDone_out  out  1  one-cycle pulse in final cycle of each instruction
  InstrCount_out  out  32  retired instruction count
  Halted_out  out  1  high while in HALT

Function
REQ-002 States/codes SHALL be IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101; codes 110/111 SHALL go to IF next cycle with all enables low.
REQ-003 Opcode classes SHALL be: R 000000, ADDI 001000, LW 100011, SW 101011, BEQ 000100, J 000010, HALT 111111; any other opcode SHALL be NOP.
REQ-004 IF SHALL assert IRWrite_en and SHALL go to ID.
REQ-005 In ID the block SHALL latch Opcode_in into an internal opcode register, and all later states SHALL decode from that register only.
REQ-006 ID transitions SHALL be: J or NOP -> IF (final cycle); HALT -> HALT; all others -> EXE.
REQ-007 EXE transitions SHALL be: BEQ -> IF (final cycle); LW or SW -> MEM; R or ADDI -> WB.
REQ-008 MEM SHALL assert MemRead_en for LW then go to WB, and SHALL assert MemWrite_en for SW then go to IF (final cycle).
REQ-009 WB SHALL assert RegWrite_en, with RegDst_out=1 only for R and MemToReg_out=1 only for LW, then go to IF (final cycle).
REQ-010 ALUSrcB_out SHALL be 1 in EXE and MEM for ADDI, LW and SW, and 0 otherwise.
REQ-011 PCWrite_en SHALL be high exactly in the final cycle of an instruction, with PCSrc_out 00 by default, 10 for J, and for BEQ 01 if Zero_in=1 else 00.
REQ-012 All outputs except InstrCount_out and the state SHALL be combinational decodes of state and opcode register; every non-asserted enable SHALL be 0 and every non-asserted select SHALL be 0.
REQ-013 Latencies SHALL be: J/NOP 2 cycles, BEQ 3, R/ADDI/SW 4, LW 5, counted from entering IF to returning to IF.
REQ-014 InstrDone_out SHALL equal PCWrite_en, and InstrCount_out SHALL increment by 1 at each posedge where InstrDone_out=1, wrapping from FFFFFFFF to 0.
REQ-015 HALT SHALL hold state, keep PCWrite_en=0 and Halted_out=1, and leave it only through reset; the HALT instruction SHALL not increment InstrCount_out.

Reset
REQ-016 Reset_in=1 at a posedge SHALL set state=IF, opcode register=000000 and InstrCount_out=0, overriding any transition, including mid-instruction and in HALT.
REQ-017 Reset SHALL take priority over every other input, and while held IF-state outputs SHALL be visible (IRWrite_en=1, PCWrite_en=0).
REQ-018 The first non-reset cycle SHALL be an IF.

Verification
REQ-019 Reset, then R opcode 000000 -> states 000,001,010,100,000; RegWrite_en=1 and RegDst_out=1 in WB; PCWrite_en=1 only in WB; count=1.
REQ-020 LW 100011 -> states IF,ID,EXE,MEM,WB; MemRead_en in MEM; MemToReg_out=1 in WB; count=1 after 5 cycles.
REQ-021 BEQ with Zero_in=1 in EXE -> PCSrc_out=01 and PCWrite_en=1 in EXE; repeated with Zero_in=0 -> PCSrc_out=00; 3 cycles each.
REQ-022 J 000010 then opcode 010101 -> each takes 2 cycles; PCSrc_out=10 in J's ID and 00 for the NOP; count +2.
REQ-023 HALT 111111 -> HALT after ID; Halted_out=1 and PCHalt_en=1 for 20 cycles; count unchanged; Reset_in=1 -> IF next cycle with count=0.
REQ-024 Reset_in pulsed during MEM of SW -> MemWrite_en not asserted at that posedge; state=IF and count=0 afterwards.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// Multi-cycle datapath controller: IF/ID/EXE/MEM/WB/HALT sequencer with
// combinational control decode and a retired-instruction counter.
module multi_cycle_controller (
    input  logic        CLK_in,
    input  logic        Reset_in,
    input  logic [5:0]  Opcode_in,
    input  logic        Zero_in,
    output logic [2:0]  State_out,
    output logic        IRWrite_en,
    output logic        PCWrite_en,
    output logic        PCHalt_en,
    output logic [1:0]  PCSrc_out,
    output logic        ALUSrcB_out,
    output logic        MemRead_en,
    output logic        MemWrite_en,
    output logic        RegWrite_en,
    output logic        MemToReg_out,
    output logic        RegDst_out,
    output logic        InstrDone_out,
    output logic [31:0] InstrCount_out,
    output logic        Halted_out
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_HALT, C_NOP
    } op_class_t;

    function automatic op_class_t classify(input logic [5:0] op);
        case (op)
            6'b000000: classify = C_R;
            6'b001000: classify = C_ADDI;
            6'b100011: classify = C_LW;
            6'b101011: classify = C_SW;
            6'b000100: classify = C_BEQ;
            6'b000010: classify = C_J;
            6'b111111: classify = C_HALT;
            default:   classify = C_NOP;
        endcase
    endfunction

    state_t      state_q, state_d, cur_state;
    logic [5:0]  opcode_q;
    logic [31:0] instr_count_q;
    op_class_t   op_class;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset wins over all transitions.
    always_ff @(posedge CLK_in) begin
        if (Reset_in) begin
            state_q       <= S_IF;
            opcode_q      <= 6'b000000;
            instr_count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID)
                opcode_q <= Opcode_in;
            if (InstrDone_out)
                instr_count_q <= instr_count_q + 32'd1;
        end
    end

    // ID decides from the live opcode (the register loads at the end of ID);
    // every later state sees only the latched copy.
    assign op_class = classify((state_q == S_ID) ? Opcode_in : opcode_q);

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = S_IF;
        IRWrite_en   = 1'b0;
        PCWrite_en   = 1'b0;
        PCSrc_out    = 2'b00;
        ALUSrcB_out  = 1'b0;
        MemRead_en   = 1'b0;
        MemWrite_en  = 1'b0;
        RegWrite_en  = 1'b0;
        MemToReg_out = 1'b0;
        RegDst_out   = 1'b0;
        Halted_out   = 1'b0;

        // While reset is held the outputs present a clean IF cycle.
        cur_state = Reset_in ? S_IF : state_q;

        case (cur_state)
            S_IF: begin
                IRWrite_en = 1'b1;
                state_d    = S_ID;
            end
            S_ID: begin
                case (op_class)
                    C_J: begin
                        PCWrite_en = 1'b1;
                        PCSrc_out  = 2'b10;
                        state_d    = S_IF;
                    end
                    C_NOP: begin
                        PCWrite_en = 1'b1;
                        state_d    = S_IF;
                    end
                    C_HALT:  state_d = S_HALT;
                    default: state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                case (op_class)
                    C_BEQ: begin
                        PCWrite_en = 1'b1;
                        PCSrc_out  = Zero_in ? 2'b01 : 2'b00;
                        state_d    = S_IF;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    C_R, C_ADDI: state_d = S_WB;
                    default:    state_d = S_IF;
                endcase
            end
            S_MEM: begin
                case (op_class)
                    C_LW: begin
                        MemRead_en = 1'b1;
                        state_d    = S_WB;
                    end
                    C_SW: begin
                        MemWrite_en = 1'b1;
                        PCWrite_en  = 1'b1;
                        state_d     = S_IF;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_WB: begin
                RegWrite_en  = 1'b1;
                RegDst_out   = (op_class == C_R);
                MemToReg_out = (op_class == C_LW);
                PCWrite_en   = 1'b1;
                state_d      = S_IF;
            end
            S_HALT: begin
                Halted_out = 1'b1;
                state_d    = S_HALT;
            end
            default: state_d = S_IF;
        endcase

        if ((cur_state == S_EXE || cur_state == S_MEM) &&
            (op_class == C_ADDI || op_class == C_LW || op_class == C_SW))
            ALUSrcB_out = 1'b1;
    end

    assign PCHalt_en      = ~PCWrite_en;
    assign InstrDone_out  = PCWrite_en;
    assign State_out      = state_q;
    assign InstrCount_out = instr_count_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_multi_cycle_controller;

    logic        CLK_in = 1'b0;
    logic        Reset_in;
    logic [5:0]  Opcode_in;
    logic        Zero_in;
    logic [2:0]  State_out;
    logic        IRWrite_en, PCWrite_en, PCHalt_en;
    logic [1:0]  PCSrc_out;
    logic        ALUSrcB_out, MemRead_en, MemWrite_en, RegWrite_en;
    logic        MemToReg_out, RegDst_out, InstrDone_out, Halted_out;
    logic [31:0] InstrCount_out;

    multi_cycle_controller dut (
        .CLK_in        (CLK_in),
        .Reset_in      (Reset_in),
        .Opcode_in     (Opcode_in),
        .Zero_in       (Zero_in),
        .State_out     (State_out),
        .IRWrite_en    (IRWrite_en),
        .PCWrite_en    (PCWrite_en),
        .PCHalt_en     (PCHalt_en),
        .PCSrc_out     (PCSrc_out),
        .ALUSrcB_out   (ALUSrcB_out),
        .MemRead_en    (MemRead_en),
        .MemWrite_en   (MemWrite_en),
        .RegWrite_en   (RegWrite_en),
        .MemToReg_out  (MemToReg_out),
        .RegDst_out    (RegDst_out),
        .InstrDone_out (InstrDone_out),
        .InstrCount_out(InstrCount_out),
        .Halted_out    (Halted_out)
    );

    always #5 CLK_in = ~CLK_in;

    // Control word: {IRW,PCW,PCH,PCSrc[1:0],ALUB,MRD,MWR,RGW,M2R,RDST,DONE,HLT}
    localparam logic [12:0] IRW = 13'h1000, PCW = 13'h0800, PCH = 13'h0400;
    localparam logic [12:0] SRC_BR = 13'h0100, SRC_J = 13'h0200, ALUB = 13'h0080;
    localparam logic [12:0] MRD = 13'h0040, MWR = 13'h0020, RGW = 13'h0010;
    localparam logic [12:0] M2R = 13'h0008, RDST = 13'h0004, DONE = 13'h0002, HLT = 13'h0001;
    localparam logic [12:0] K_IF = IRW | PCH, K_WAIT = PCH, K_FIN = PCW | DONE;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_HALT = 6'b111111, OP_NOP = 6'b010101;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [12:0] ctrl;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the DUT presents a new control word every cycle.
    always @(negedge CLK_in) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [12:0] act_ctrl;
            e = exp_q.pop_front();
            act_ctrl = {IRWrite_en, PCWrite_en, PCHalt_en, PCSrc_out, ALUSrcB_out, MemRead_en,
                        MemWrite_en, RegWrite_en, MemToReg_out, RegDst_out, InstrDone_out, Halted_out};
            check({e.tag, ".state"}, {29'd0, State_out}, {29'd0, e.st});
            check({e.tag, ".ctrl"},  {19'd0, act_ctrl},  {19'd0, e.ctrl});
            check({e.tag, ".count"}, InstrCount_out,     e.cnt);
        end
    end

    // Drive one cycle and queue the response expected during it.
    task automatic cyc(input string tag, input logic rst, input logic [5:0] op, input logic z,
                       input logic [2:0] st, input logic [12:0] ctrl, input logic [31:0] cnt);
        exp_t e;
        Reset_in  = rst;
        Opcode_in = op;
        Zero_in   = z;
        e.tag = tag; e.st = st; e.ctrl = ctrl; e.cnt = cnt;
        exp_q.push_back(e);
        @(posedge CLK_in);
        #1;
    endtask

    initial begin
        Reset_in  = 1'b1;
        Opcode_in = OP_R;
        Zero_in   = 1'b0;
        @(posedge CLK_in);
        #1;
        cyc("rst", 1, OP_R, 0, S_IF, K_IF, 0);

        // R-type; opcode bus carries junk after ID to prove latching
        cyc("r_if",  0, OP_R,    0, S_IF,  K_IF,   0);
        cyc("r_id",  0, OP_R,    0, S_ID,  K_WAIT, 0);
        cyc("r_exe", 0, OP_HALT, 0, S_EXE, K_WAIT, 0);
        cyc("r_wb",  0, OP_HALT, 0, S_WB,  RGW | RDST | K_FIN, 0);

        cyc("lw_if",  0, OP_LW, 0, S_IF,  K_IF,   1);
        cyc("lw_id",  0, OP_LW, 0, S_ID,  K_WAIT, 1);
        cyc("lw_exe", 0, OP_J,  0, S_EXE, K_WAIT | ALUB, 1);
        cyc("lw_mem", 0, OP_J,  0, S_MEM, K_WAIT | ALUB | MRD, 1);
        cyc("lw_wb",  0, OP_J,  0, S_WB,  RGW | M2R | K_FIN, 1);

        cyc("addi_if",  0, OP_ADDI, 0, S_IF,  K_IF,   2);
        cyc("addi_id",  0, OP_ADDI, 0, S_ID,  K_WAIT, 2);
        cyc("addi_exe", 0, OP_ADDI, 0, S_EXE, K_WAIT | ALUB, 2);
        cyc("addi_wb",  0, OP_ADDI, 0, S_WB,  RGW | K_FIN, 2);

        cyc("beq1_if",  0, OP_BEQ, 0, S_IF,  K_IF,   3);
        cyc("beq1_id",  0, OP_BEQ, 0, S_ID,  K_WAIT, 3);
        cyc("beq1_exe", 0, OP_BEQ, 1, S_EXE, SRC_BR | K_FIN, 3);
        cyc("beq0_if",  0, OP_BEQ, 0, S_IF,  K_IF,   4);
        cyc("beq0_id",  0, OP_BEQ, 0, S_ID,  K_WAIT, 4);
        cyc("beq0_exe", 0, OP_BEQ, 0, S_EXE, K_FIN,  4);

        cyc("j_if",   0, OP_J,   0, S_IF, K_IF,          5);
        cyc("j_id",   0, OP_J,   0, S_ID, SRC_J | K_FIN, 5);
        cyc("nop_if", 0, OP_NOP, 0, S_IF, K_IF,          6);
        cyc("nop_id", 0, OP_NOP, 0, S_ID, K_FIN,         6);

        // SW aborted by reset in MEM: no write strobe, state and count cleared
        cyc("swr_if",  0, OP_SW, 0, S_IF,  K_IF,   7);
        cyc("swr_id",  0, OP_SW, 0, S_ID,  K_WAIT, 7);
        cyc("swr_exe", 0, OP_SW, 0, S_EXE, K_WAIT | ALUB, 7);
        cyc("swr_mem", 1, OP_SW, 0, S_MEM, K_IF,   7);

        cyc("sw_if",  0, OP_SW, 0, S_IF,  K_IF,   0);
        cyc("sw_id",  0, OP_SW, 0, S_ID,  K_WAIT, 0);
        cyc("sw_exe", 0, OP_SW, 0, S_EXE, K_WAIT | ALUB, 0);
        cyc("sw_mem", 0, OP_SW, 0, S_MEM, K_WAIT & 13'h0 | ALUB | MWR | K_FIN, 0);

        cyc("halt_if", 0, OP_HALT, 0, S_IF, K_IF,   1);
        cyc("halt_id", 0, OP_HALT, 0, S_ID, K_WAIT, 1);
        for (int i = 0; i < 20; i++)
            cyc("halt_hold", 0, OP_R, 0, S_HALT, K_WAIT | HLT, 1);
        cyc("halt_rst", 1, OP_R, 0, S_HALT, K_IF, 1);

        cyc("post_if",  0, OP_NOP, 0, S_IF, K_IF,  0);
        cyc("post_id",  0, OP_NOP, 0, S_ID, K_FIN, 0);
        cyc("post_if2", 0, OP_NOP, 0, S_IF, K_IF,  1);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(negedge CLK_in);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
